hist_ram_sequencer: RTL and testbench

Controller that owns the single-port 32-bit histogram RAM and serializes three requesters onto it: pixel accumulation (read-modify-write increment), bulk clear, and sequential readout (dump) toward the result writer. It sits between the pixel stream coming out of the image RAM and the histogram-table RAM, replacing ad-hoc delay counters with explicit valid/ready handshakes.

---
 rtl/hist_pkg.sv | 24 ++
 rtl/hist_ram_sequencer.sv | 149 ++++++++++++++
 tb/tb_hist_ram_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// -----------------------------------------------------------------------------
// hist_pkg
// Shared definitions for the histogram datapath: table geometry and the
// encoding of the histogram RAM sequencer states. Also used by the top level
// and the histogram RAM instance so all of them agree on table size.
// -----------------------------------------------------------------------------
package hist_pkg;

    localparam int HIST_NBINS  = 256;
    localparam int HIST_BIN_W  = 32;
    localparam int HIST_ADDR_W = 8;

    // Explicit encodings keep the state values stable for legacy debug taps.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_ACC_RD  = 3'd2,
        ST_ACC_WR  = 3'd3,
        ST_DMP_RD  = 3'd4,
        ST_DMP_CAP = 3'd5,
        ST_DMP_OUT = 3'd6
    } hist_state_e;

endpackage

// File: rtl/hist_ram_sequencer.sv
// -----------------------------------------------------------------------------
// hist_ram_sequencer
// Owns the single-port histogram RAM and serializes three requesters onto it:
// pixel accumulation (read-modify-write increment), bulk clear and sequential
// readout (dump) toward the result writer.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   clear_i, dump_i       level requests, sampled only in IDLE
//   pix_valid_i/ready_o   pixel stream handshake, pix_data_i = bin index
//   out_valid_o/ready_i   dump stream handshake, out_bin_o / out_count_o
//   busy_o                high whenever the sequencer is not IDLE
//   done_o                one-cycle pulse after a clear or dump completes
//   ram_*                 RAM port; controls are Moore outputs of the state,
//                         ram_data_i is valid the cycle after a read
// -----------------------------------------------------------------------------
module hist_ram_sequencer
    import hist_pkg::*;
#(
    parameter int NBINS  = HIST_NBINS,
    parameter int ADDR_W = HIST_ADDR_W,
    parameter int BIN_W  = HIST_BIN_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              dump_i,
    input  logic              pix_valid_i,
    input  logic [ADDR_W-1:0] pix_data_i,
    output logic              pix_ready_o,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_bin_o,
    output logic [BIN_W-1:0]  out_count_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [BIN_W-1:0]  ram_data_o,
    input  logic [BIN_W-1:0]  ram_data_i
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NBINS - 1);
    localparam logic [BIN_W-1:0]  BIN_MAX  = {BIN_W{1'b1}};

    hist_state_e       state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] pix_q;
    logic [ADDR_W-1:0] out_bin_q;
    logic [BIN_W-1:0]  out_count_q;
    logic              done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pix_q       <= '0;
            out_bin_q   <= '0;
            out_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_i) begin
                        idx   <= '0;
                        state <= ST_CLR;
                    end else if (dump_i) begin
                        idx   <= '0;
                        state <= ST_DMP_RD;
                    end else if (pix_valid_i) begin
                        pix_q <= pix_data_i;
                        state <= ST_ACC_RD;
                    end
                end
                ST_CLR: begin
                    // idx wraps back to 0 after the last bin, ready for the next op.
                    idx <= idx + ADDR_W'(1);
                    if (idx == LAST_IDX) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                ST_ACC_RD:  state <= ST_ACC_WR;
                ST_ACC_WR:  state <= ST_IDLE;
                ST_DMP_RD:  state <= ST_DMP_CAP;
                ST_DMP_CAP: begin
                    out_count_q <= ram_data_i;
                    out_bin_q   <= idx;
                    state       <= ST_DMP_OUT;
                end
                ST_DMP_OUT: begin
                    if (out_ready_i) begin
                        if (idx == LAST_IDX) begin
                            idx    <= '0;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_DMP_RD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM port is a pure function of the current state. The write in ACC_WR
    // lands before the next pixel's read, so back-to-back same-bin pixels are safe.
    always_comb begin
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        case (state)
            ST_CLR: begin
                ram_en_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_addr_o = idx;
            end
            ST_ACC_RD: begin
                ram_en_o   = 1'b1;
                ram_addr_o = pix_q;
            end
            ST_ACC_WR: begin
                ram_en_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_addr_o = pix_q;
                ram_data_o = (ram_data_i == BIN_MAX) ? ram_data_i : ram_data_i + BIN_W'(1);
            end
            ST_DMP_RD: begin
                ram_en_o   = 1'b1;
                ram_addr_o = idx;
            end
            default: ;
        endcase
    end

    // Gated by rst_i so every output reads 0 while reset is held.
    assign pix_ready_o = (state == ST_IDLE) && !rst_i && !clear_i && !dump_i;
    assign busy_o      = (state != ST_IDLE);
    assign done_o      = done_q;
    assign out_valid_o = (state == ST_DMP_OUT);
    assign out_bin_o   = out_bin_q;
    assign out_count_o = out_count_q;

endmodule

// File: tb/tb_hist_ram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hist_ram_sequencer
// Directed bench for hist_ram_sequencer with a behavioural single-port RAM.
// A reference histogram is kept alongside the stimulus; expected dump words
// are queued when a dump is requested and popped on each output handshake.
// -----------------------------------------------------------------------------
module tb_hist_ram_sequencer;
    import hist_pkg::*;

    localparam int NB = HIST_NBINS;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        clear_i, dump_i, pix_valid_i, out_ready_i;
    logic [7:0]  pix_data_i;
    logic        pix_ready_o, out_valid_o, busy_o, done_o, ram_en_o, ram_we_o;
    logic [7:0]  out_bin_o, ram_addr_o;
    logic [31:0] out_count_o, ram_data_o, ram_data_i;

    // Bench-side preload port into the RAM model.
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    logic [31:0] mem [NB];
    logic [31:0] ref_h [NB];

    typedef struct packed {
        logic [7:0]  bin;
        logic [31:0] cnt;
    } word_t;
    word_t exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
            else          ram_data_i      <= mem[ram_addr_o];
        end
    end

    hist_ram_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .dump_i      (dump_i),
        .pix_valid_i (pix_valid_i),
        .pix_data_i  (pix_data_i),
        .pix_ready_o (pix_ready_o),
        .out_valid_o (out_valid_o),
        .out_bin_o   (out_bin_o),
        .out_count_o (out_count_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 50) begin
            step();
            n++;
        end
        chk("wait_idle", {63'd0, busy_o}, 64'd0);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] v);
        int n = 0;
        pix_valid_i = 1'b1;
        pix_data_i  = v;
        while (!pix_ready_o && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("pix_accept_timeout", 64'd0, 64'd1);
        step();
        pix_valid_i = 1'b0;
        if (ref_h[v] != 32'hFFFF_FFFF) ref_h[v] = ref_h[v] + 32'd1;
    endtask

    task automatic do_clear();
        int n = 0;
        wait_idle();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        while (!done_o && n < 400) begin
            step();
            n++;
        end
        chk("clear_done_latency", 64'(n), 64'd256);
        for (int i = 0; i < NB; i++) ref_h[i] = 32'd0;
        step();
        chk("clear_done_pulse", {63'd0, done_o}, 64'd0);
    endtask

    task automatic fill_expected();
        word_t w;
        exp_q.delete();
        for (int i = 0; i < NB; i++) begin
            w.bin = 8'(i);
            w.cnt = ref_h[i];
            exp_q.push_back(w);
        end
    endtask

    // Consumes dump words after the dump has been accepted; optionally stalls
    // 10 cycles when bin stall_bin is presented.
    task automatic consume(input int stall_bin, input int exp_edges, output logic [63:0] sum);
        int          edges = 0;
        int          stalls = 0;
        logic [63:0] s = 64'd0;
        word_t       w;
        out_ready_i = 1'b1;
        while (edges < 4000) begin
            if (out_valid_o && (32'(out_bin_o) == stall_bin) && stalls < 10) begin
                out_ready_i = 1'b0;
                if (exp_q.size() > 0) begin
                    chk("stall_bin_stable", 64'(out_bin_o), 64'(exp_q[0].bin));
                    chk("stall_count_stable", 64'(out_count_o), 64'(exp_q[0].cnt));
                end
                chk("stall_no_ram", {63'd0, ram_en_o}, 64'd0);
                chk("stall_pix_ready", {63'd0, pix_ready_o}, 64'd0);
                stalls++;
            end else if (out_valid_o) begin
                out_ready_i = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("dump_extra_word", 64'(out_bin_o), 64'hFFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("dump_bin", 64'(out_bin_o), 64'(w.bin));
                    chk("dump_count", 64'(out_count_o), 64'(w.cnt));
                    s = s + 64'(out_count_o);
                end
            end else begin
                out_ready_i = 1'b1;
            end
            step();
            edges++;
            if (done_o) break;
        end
        out_ready_i = 1'b1;
        chk("dump_done_latency", 64'(edges), 64'(exp_edges));
        chk("dump_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("dump_stall_cycles", 64'(stalls), (stall_bin >= 0) ? 64'd10 : 64'd0);
        step();
        chk("dump_done_pulse", {63'd0, done_o}, 64'd0);
        sum = s;
    endtask

    task automatic do_dump(input int stall_bin, input int exp_edges, output logic [63:0] sum);
        wait_idle();
        fill_expected();
        dump_i = 1'b1;
        step();
        dump_i = 1'b0;
        consume(stall_bin, exp_edges, sum);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sum;
        logic [7:0]  last;
        int          n;

        rst_i       = 1'b1;
        clear_i     = 1'b0;
        dump_i      = 1'b0;
        pix_valid_i = 1'b0;
        pix_data_i  = 8'd0;
        out_ready_i = 1'b1;
        pre_we      = 1'b0;
        pre_addr    = 8'd0;
        pre_data    = 32'd0;
        for (int i = 0; i < NB; i++) ref_h[i] = 32'd0;

        // Reset state
        repeat (3) step();
        chk("rst_pix_ready", {63'd0, pix_ready_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_ram_en", {63'd0, ram_en_o}, 64'd0);
        chk("rst_out_count", 64'(out_count_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_pix_ready", {63'd0, pix_ready_o}, 64'd1);

        // Clear, then 5,5,5,200, then full-speed dump
        do_clear();
        send_pix(8'd5);
        send_pix(8'd5);
        send_pix(8'd5);
        send_pix(8'd200);
        chk("ref_bin5", 64'(ref_h[5]), 64'd3);
        do_dump(-1, 768, sum);
        chk("dump1_sum", sum, 64'd4);

        // Saturation boundary
        wait_idle();
        preload(8'd7, 32'hFFFF_FFFF);
        preload(8'd6, 32'hFFFF_FFFE);
        ref_h[7] = 32'hFFFF_FFFF;
        ref_h[6] = 32'hFFFF_FFFE;
        send_pix(8'd7);
        send_pix(8'd6);
        wait_idle();
        chk("sat_bin7", 64'(mem[7]), 64'h0000_0000_FFFF_FFFF);
        chk("sat_bin6", 64'(mem[6]), 64'h0000_0000_FFFF_FFFF);

        // Dump with a 10-cycle stall at bin 3
        do_dump(3, 778, sum);

        // Priority: clear beats dump beats pixel
        wait_idle();
        clear_i     = 1'b1;
        dump_i      = 1'b1;
        pix_valid_i = 1'b1;
        pix_data_i  = 8'd9;
        #1;
        chk("prio_pix_ready", {63'd0, pix_ready_o}, 64'd0);
        step();
        chk("prio_clr_we", {63'd0, ram_we_o}, 64'd1);
        chk("prio_clr_addr", 64'(ram_addr_o), 64'd0);
        clear_i = 1'b0;
        n = 0;
        while (!done_o && n < 400) begin
            step();
            n++;
        end
        chk("prio_clear_latency", 64'(n), 64'd256);
        for (int i = 0; i < NB; i++) ref_h[i] = 32'd0;
        chk("prio_dump_blocks_pix", {63'd0, pix_ready_o}, 64'd0);
        fill_expected();
        step();
        dump_i      = 1'b0;
        pix_valid_i = 1'b0;
        chk("prio_dmp_rd_en", {63'd0, ram_en_o}, 64'd1);
        chk("prio_dmp_rd_we", {63'd0, ram_we_o}, 64'd0);
        chk("prio_dmp_rd_addr", 64'(ram_addr_o), 64'd0);
        consume(-1, 768, sum);
        chk("prio_sum", sum, 64'd0);

        // 1000 random pixels with random gaps
        do_clear();
        last = 8'd0;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 3) != 0) last = 8'($urandom_range(0, 255));
            send_pix(last);
        end
        do_dump(-1, 768, sum);
        chk("rand_sum", sum, 64'd1000);

        // Reset in the middle of a clear at idx=100
        wait_idle();
        for (int i = 0; i < NB; i++) preload(8'(i), 32'hA000_0000 | 32'(i));
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        n = 0;
        while (!(ram_we_o && ram_addr_o == 8'd100) && n < 300) begin
            step();
            n++;
        end
        chk("rst_reach_idx100", 64'(ram_addr_o), 64'd100);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_ram_en", {63'd0, ram_en_o}, 64'd0);
        chk("mid_rst_ram_we", {63'd0, ram_we_o}, 64'd0);
        chk("mid_rst_ram_addr", 64'(ram_addr_o), 64'd0);
        chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
        chk("mid_rst_pix_ready", {63'd0, pix_ready_o}, 64'd0);
        chk("mid_rst_done", {63'd0, done_o}, 64'd0);
        step();
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_idle", {63'd0, busy_o}, 64'd0);
        chk("post_rst_ready", {63'd0, pix_ready_o}, 64'd1);
        chk("mid_rst_bin99", 64'(mem[99]), 64'd0);
        chk("mid_rst_bin100", 64'(mem[100]), 64'hA000_0064);
        chk("mid_rst_bin255", 64'(mem[255]), 64'hA000_00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
